// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared types, 7-segment glyph table and stretcher states
package processor_pkg;

  typedef logic [9:0] word_t;
  typedef logic [1:0] tstep_t;
  typedef logic [6:0] seg_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_LUT[16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    S_IDLE,
    S_LIT
  } stretch_state_t;

endpackage

// File: rtl/bus_output_port_if.sv
// rtl/bus_output_port_if.sv - data bus capture handshake between controller and output port
interface bus_output_port_if;
  import processor_pkg::*;

  word_t DataBus;
  logic  out_en;
  logic  hold;
  logic  out_ack;

  modport master (
    output DataBus,
    output out_en,
    output hold,
    input  out_ack
  );

  modport slave (
    input  DataBus,
    input  out_en,
    input  hold,
    output out_ack
  );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low 7-segment glyph
module seg7_decode
  import processor_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/bus_output_port.sv
// rtl/bus_output_port.sv - captures DataBus onto LEDs/hex digits, shows timestep, stretches done
module bus_output_port
  import processor_pkg::*;
#(
  parameter int STRETCH_CYCLES = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              Clrb,
  bus_output_port_if.slave  bus,
  input  logic              done,
  input  tstep_t            timestep,
  output word_t             LED_B,
  output seg_t              DHEX0,
  output seg_t              DHEX1,
  output seg_t              DHEX2,
  output seg_t              THEX,
  output logic              LED_D
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES - 1);

  word_t            r_cap_q;
  tstep_t           r_ts_q;
  logic             r_out_ack;
  stretch_state_t   r_state;
  stretch_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  // hold wins over a simultaneous strobe
  assign w_accept = bus.out_en && !bus.hold;

  always_ff @(posedge CLOCK_50) begin
    if (!Clrb) begin
      r_cap_q   <= '0;
      r_ts_q    <= '0;
      r_out_ack <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cap_q <= bus.DataBus;
      end
      r_ts_q    <= timestep;
      r_out_ack <= w_accept;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Clrb) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Retrigger takes priority over the terminal-count exit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (done) begin
          w_state_nxt = S_LIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_LIT: begin
        if (done) begin
          w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.out_ack = r_out_ack;
  assign LED_B       = r_cap_q;
  assign LED_D       = (r_state == S_LIT);

  seg7_decode u_hex0 (.i_nib(r_cap_q[3:0]),          .o_seg(DHEX0));
  seg7_decode u_hex1 (.i_nib(r_cap_q[7:4]),          .o_seg(DHEX1));
  seg7_decode u_hex2 (.i_nib({2'b00, r_cap_q[9:8]}), .o_seg(DHEX2));
  seg7_decode u_thex (.i_nib({2'b00, r_ts_q}),       .o_seg(THEX));

endmodule

// File: tb/tb_bus_output_port.sv
// tb/tb_bus_output_port.sv - self-checking bench for bus_output_port
module tb_bus_output_port;

  logic       clk = 1'b0;
  logic       clrb;
  logic       done;
  logic [1:0] ts;
  logic [9:0] led_b;
  logic [6:0] dhex0, dhex1, dhex2, thex;
  logic       led_d;

  always #5 clk = ~clk;

  bus_output_port_if bus_if ();

  bus_output_port #(.STRETCH_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .Clrb     (clrb),
    .bus      (bus_if),
    .done     (done),
    .timestep (ts),
    .LED_B    (led_b),
    .DHEX0    (dhex0),
    .DHEX1    (dhex1),
    .DHEX2    (dhex2),
    .THEX     (thex),
    .LED_D    (led_d)
  );

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [9:0] data;
    logic       en;
    logic       hold;
    logic [9:0] exp_led;
    logic       exp_ack;
  } vec_t;

  typedef struct {
    logic [9:0] led;
    logic       ack;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       e;
    logic [3:0] nib;
    logic [4:0] pat_s;
    logic [6:0] pat_r;

    // Reset held with every input trying to disturb it
    clrb = 1'b0; done = 1'b1; ts = 2'd0;
    bus_if.DataBus = 10'h3FF; bus_if.out_en = 1'b1; bus_if.hold = 1'b0;
    repeat (3) tick();
    clrb = 1'b1; done = 1'b0; bus_if.out_en = 1'b0; bus_if.DataBus = 10'h000;
    chk("rst_led_b", led_b, 0);
    chk("rst_dhex0", dhex0, 7'b1000000);
    chk("rst_dhex1", dhex1, 7'b1000000);
    chk("rst_dhex2", dhex2, 7'b1000000);
    chk("rst_thex",  thex,  7'b1000000);
    chk("rst_led_d", led_d, 0);
    chk("rst_ack",   bus_if.out_ack, 0);

    vecs[0] = '{10'h2A5, 1'b1, 1'b0, 10'h2A5, 1'b1};
    vecs[1] = '{10'h111, 1'b0, 1'b0, 10'h2A5, 1'b0};
    vecs[2] = '{10'h015, 1'b1, 1'b0, 10'h015, 1'b1};
    vecs[3] = '{10'h3C0, 1'b1, 1'b1, 10'h015, 1'b0};
    vecs[4] = '{10'h3C0, 1'b0, 1'b1, 10'h015, 1'b0};
    vecs[5] = '{10'h3C0, 1'b1, 1'b0, 10'h3C0, 1'b1};
    vecs[6] = '{10'h001, 1'b1, 1'b0, 10'h001, 1'b1};
    vecs[7] = '{10'h3FF, 1'b1, 1'b0, 10'h3FF, 1'b1};
    vecs[8] = '{10'h3FF, 1'b0, 1'b0, 10'h3FF, 1'b0};

    for (int i = 0; i < 9; i++) begin
      bus_if.DataBus = vecs[i].data;
      bus_if.out_en  = vecs[i].en;
      bus_if.hold    = vecs[i].hold;
      sb.push_back('{vecs[i].exp_led, vecs[i].exp_ack});
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d_led_b", i), led_b, e.led);
      chk($sformatf("v%0d_ack", i), bus_if.out_ack, e.ack);
      nib = e.led[3:0];
      chk($sformatf("v%0d_dhex0", i), dhex0, glyph[nib]);
      nib = e.led[7:4];
      chk($sformatf("v%0d_dhex1", i), dhex1, glyph[nib]);
      nib = {2'b00, e.led[9:8]};
      chk($sformatf("v%0d_dhex2", i), dhex2, glyph[nib]);
    end
    bus_if.out_en = 1'b0; bus_if.hold = 1'b0;

    // Fixed glyphs for the digits called out explicitly
    bus_if.DataBus = 10'h2A5; bus_if.out_en = 1'b1;
    tick();
    bus_if.out_en = 1'b0;
    chk("cap_dhex0_5", dhex0, 7'b0010010);
    chk("cap_dhex1_A", dhex1, 7'b0001000);
    chk("cap_dhex2_2", dhex2, 7'b0100100);
    bus_if.DataBus = 10'h0F0;
    tick();
    chk("cap_ack_once", bus_if.out_ack, 0);
    chk("cap_hold_val", led_b, 10'h2A5);

    for (int i = 0; i < 4; i++) begin
      ts = 2'(i);
      tick();
      chk($sformatf("thex_%0d", i), thex, glyph[i]);
    end

    // Single done pulse: lit for exactly four cycles
    repeat (2) tick();
    chk("stretch_idle", led_d, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    pat_s = 5'b01111;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stretch_c%0d", 11 + k), led_d, pat_s[k]);
      tick();
    end

    // done at cycle 10 and 12: lit through cycle 16
    repeat (3) tick();
    chk("retrig_idle", led_d, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    pat_r = 7'b0111111;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("retrig_c%0d", 11 + k), led_d, pat_r[k]);
      done = (k == 1);
      tick();
    end
    done = 1'b0;

    // Reset in the middle of a stretch
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("midlit_on", led_d, 1);
    clrb = 1'b0;
    tick();
    clrb = 1'b1;
    chk("midlit_rst_led_d", led_d, 0);
    chk("midlit_rst_led_b", led_b, 0);
    chk("midlit_rst_thex", thex, 7'b1000000);
    tick();
    chk("midlit_stays_off", led_d, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_output_port.md
# bus_output_port

Output end of the 10-bit processor's shared data bus: the counterpart of the external data receiver that puts switch data onto `DataBus`. The block captures a bus value when the controller strobes it, and holds that value on the red LEDs and on three hex digits. It shows the current timestep on HEX5 and stretches the controller's one-cycle done pulse into a visible LED. It sits at the top level between `DataBus`/controller and the board outputs.

## Interface
- `STRETCH_CYCLES`, 25_000_000, number of cycles LED_D stays lit after a done pulse (0.5 s at 50 MHz); legal range is 1 or more.
- `CLOCK_50`  input  1  sole clock; every flop is on the rising edge.
- `Clrb`  input  1  reset: synchronous, active-low.
- `DataBus`  input  10  shared processor data bus.
- `out_en`  input  1  capture strobe from the controller; DataBus is valid during this cycle.
- `hold`  input  1  freeze the displayed value; captures are suppressed while high.
- `done`  input  1  instruction-complete pulse from the controller.
- `timestep`  input  2  current controller timestep, 0–3.
- `out_ack`  output  1  one-cycle acknowledge of an accepted capture.
- `LED_B`  output  10  captured value.
- `DHEX0`  output  7  hex digit for captured value [3:0].
- `DHEX1`  output  7  hex digit for captured value [7:4].
- `DHEX2`  output  7  hex digit for captured value [9:8], zero-extended to 4 bits.
- `THEX`  output  7  hex digit for timestep, zero-extended.
- `LED_D`  output  1  stretched done indicator.

## Operation
- **Capture register `cap_q` (10 bits):**
  - On a clock edge with `out_en`=1 and `hold`=0: `cap_q` ← `DataBus`, and `out_ack`=1 on the following cycle.
  - On an edge with `out_en`=1 and `hold`=1: no capture, and `out_ack` stays 0 (hold wins).
  - Back-to-back `out_en` captures every cycle. Each accepted capture produces its own `out_ack` cycle.
- **Outputs from `cap_q`:**
  - `LED_B` = `cap_q`.
  - `DHEX0`/`DHEX1`/`DHEX2` are decoded from `cap_q` through the 7-segment decoder.
  - Segments are active-low in {g,f,e,d,c,b,a} order.
  - Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Timestep display:** `ts_q` ← `timestep` every cycle, and `THEX` is decoded from `ts_q`.
- **Done stretcher FSM:**
  - States are IDLE and LIT, with a down-counter `cnt` of width $clog2(STRETCH_CYCLES+1).
  - IDLE: on `done`=1, go to LIT and load `cnt`=STRETCH_CYCLES−1.
  - LIT: if `done`=1, reload `cnt`=STRETCH_CYCLES−1 (retrigger). Otherwise, if `cnt`=0, go to IDLE; otherwise decrement.
  - `LED_D` = (state == LIT), registered.
- **Reset (`Clrb`=0 at an edge):** `cap_q`=0, `ts_q`=0, `out_ack`=0, FSM to IDLE, `cnt`=0.
  - Outputs after reset: `LED_B`=0, `DHEX0..2`=1000000, `THEX`=1000000, `LED_D`=0.
  - Reset overrides `out_en`, `done` and any stretch in progress.

## Timing
- Capture latency is one cycle: `out_en` high at edge N means `LED_B`/`DHEX*`/`out_ack` change after edge N.
- `out_ack` is high for exactly one cycle per accepted capture.
- `THEX` lags `timestep` by one cycle.
- `LED_D` rises one cycle after `done`. It stays high for exactly STRETCH_CYCLES cycles after the last `done` pulse.
- With STRETCH_CYCLES=1, a single `done` gives a one-cycle `LED_D` pulse.
- The counter never underflows or wraps. `cnt`=0 in LIT always exits to IDLE unless `done` retriggers.
- The `done`-retrigger path has priority over the `cnt`=0 exit.
- All outputs are pure functions of registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `processor_pkg`:
  - `typedef logic [9:0] word_t`
  - `typedef logic [1:0] tstep_t`
  - `typedef logic [6:0] seg_t`
  - `localparam seg_t SEG_LUT[16]` holding the glyph table above.
  - The stretcher state enum `{S_IDLE, S_LIT}`.
- One sub-module, `seg7_decode` (4-bit in, `seg_t` out, combinational LUT). It is instantiated four times and is reusable by other display users.

## Test plan
- **Reset:** hold `Clrb`=0 for 3 cycles with `out_en`=1, `DataBus`=10'h3FF and `done`=1. After release: `LED_B`=0, all four HEX=1000000, `LED_D`=0, `out_ack`=0.
- **Capture:** `DataBus`=10'h2A5 with `out_en` high for one cycle. Next cycle: `LED_B`=10'h2A5, `DHEX0`=0010010, `DHEX1`=0001000, `DHEX2`=0100100, and `out_ack` high for one cycle. Afterwards `DataBus` changes and the outputs hold.
- **Hold:** capture 10'h015, then `hold`=1 and `out_en`=1 with `DataBus`=10'h3C0. Required: `LED_B` stays 10'h015 and `out_ack` stays 0. Release `hold` and strobe: `LED_B`=10'h3C0, `DHEX2`=0110000.
- **Stretch (STRETCH_CYCLES=4):** `done` pulse at cycle 10. `LED_D` is high on cycles 11–14 and low at cycle 15.
- **Retrigger:** `done` at cycles 10 and 12. `LED_D` is high on cycles 11–16.
- **Timestep:** sweep `timestep` 0,1,2,3 on consecutive cycles. `THEX` shows 1000000, 1111001, 0100100, 0110000, one cycle delayed. Then assert reset mid-LIT: `LED_D`=0 the next cycle.
